opend_flag_gen: RTL

- Producer side of the per-core operation-done flag interface used by the memory controller.
- On a controller start request, it issues a one-cycle start pulse to each enabled core.
- It latches each core's done pulse into a sticky per-core flag and drives the 16 flag lines that the controller's all-done AND stage consumes.
- It also supplies a masked completion, a watchdog timeout and a clear handshake so the next operation round can begin.

---
 rtl/opend_flag_gen_pkg.sv | 17 +
 rtl/opend_flag_lane.sv | 28 ++
 rtl/opend_flag_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/opend_flag_gen_pkg.sv
// Shared definitions for the operation-done flag producer: state encoding
// and default sizing.
package opend_flag_gen_pkg;

    localparam int          NUM_CORES_DEF  = 16;
    localparam int          TMO_W_DEF      = 16;
    localparam logic [15:0] TMO_CYCLES_DEF = 16'd1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_WAIT     = 3'd2,
        ST_DONE     = 3'd3,
        ST_TIMEOUT  = 3'd4
    } state_e;

endpackage

// File: rtl/opend_flag_lane.sv
// One sticky per-core done flag. Priority: clear, then preset load, then set.
module opend_flag_lane (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic load_val_i,
    input  logic set_i,
    output logic flag_o
);

    logic flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else if (clr_i) begin
            flag_q <= 1'b0;
        end else if (load_i) begin
            flag_q <= load_val_i;
        end else if (set_i) begin
            flag_q <= 1'b1;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/opend_flag_gen.sv
// Producer side of the per-core operation-done flag interface: dispatches
// start pulses, collects sticky done flags, and watches for a stalled round.
module opend_flag_gen
    import opend_flag_gen_pkg::*;
#(
    parameter int               NUM_CORES  = NUM_CORES_DEF,
    parameter int               TMO_W      = TMO_W_DEF,
    parameter logic [TMO_W-1:0] TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 clear,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NUM_CORES-1:0] op_flags,
    output logic                 all_done,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] CNT_LAST = TMO_CYCLES - CNT_ONE;

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [TMO_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CORES-1:0]   core_start_q;
    logic                   all_done_q, busy_q, timeout_q;

    logic [NUM_CORES-1:0]   flags;
    logic [NUM_CORES-1:0]   flags_next;
    logic [NUM_CORES-1:0]   lane_set;
    logic [NUM_CORES-1:0]   lane_load_val;
    logic                   lane_load;
    logic                   lane_clr;

    // Masked-off lanes are preset to 1 so the AND over all lanes only waits
    // on participating cores; a zero mask therefore presets every lane.
    assign lane_load_val = ~core_mask;
    assign flags_next    = flags | lane_set;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        lane_load = 1'b0;
        lane_clr  = 1'b0;
        lane_set  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lane_load = 1'b1;
                    cnt_d     = '0;
                    mask_d    = core_mask;
                    state_d   = (core_mask != '0) ? ST_DISPATCH : ST_DONE;
                end
            end
            ST_DISPATCH: begin
                lane_set = core_done & mask_q;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                lane_set = core_done & mask_q;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (&flags_next) begin
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (clear) begin
                    lane_clr = 1'b1;
                    mask_d   = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            cnt_q        <= '0;
            core_start_q <= '0;
            all_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            core_start_q <= (state_d == ST_DISPATCH) ? mask_d : '0;
            all_done_q   <= (state_d == ST_DONE);
            busy_q       <= (state_d == ST_DISPATCH) || (state_d == ST_WAIT);
            timeout_q    <= (state_d == ST_TIMEOUT);
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
        opend_flag_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (lane_clr),
            .load_i     (lane_load),
            .load_val_i (lane_load_val[g]),
            .set_i      (lane_set[g]),
            .flag_o     (flags[g])
        );
    end

    assign core_start = core_start_q;
    assign op_flags   = flags;
    assign all_done   = all_done_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;

endmodule
